// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: FSM states, owner bit, zero word.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_ACC = 2'd1,
    ST_DM_ACC = 2'd2
  } state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

endpackage

// File: rtl/ram_arb_pick.sv
// Grant decision between fetch and data requests; RAM_ARB_RR_EN selects
// round-robin on contention, otherwise DM has fixed priority. Pure combinational.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_grant,
  output logic grant_dm,
  output logic grant_valid
);

  assign grant_valid = if_req | dm_req;

`ifdef RAM_ARB_RR_EN
  // On contention hand the RAM to whichever port did not win last time.
  assign grant_dm = dm_req & (~if_req | (last_grant == OWNER_IF));
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_dm = dm_req;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between fetch and data; ack 2+ cycles after request, waits on ram_ready
// up to TIMEOUT cycles then aborts with bus_err. Arbitration mode set by RAM_ARB_RR_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_we,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        ram_ce,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state_q, state_d;
  logic          last_grant;
  logic [CW-1:0] wait_cnt;
  logic          grant_dm, grant_valid;
  logic          take, in_acc, owner_dm, finish_ok, finish_abort, acc_done;

  // A port is deaf during its own ack cycle so a lingering req cannot re-trigger.
  ram_arb_pick u_pick (
    .if_req      (if_req & ~if_ack),
    .dm_req      (dm_req & ~dm_ack),
    .last_grant  (last_grant),
    .grant_dm    (grant_dm),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = grant_dm ? ST_DM_ACC : ST_IF_ACC;
      ST_IF_ACC,
      ST_DM_ACC: if (acc_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_acc       = (state_q != ST_IDLE);
    owner_dm     = (state_q == ST_DM_ACC);
    take         = (state_q == ST_IDLE) & grant_valid;
    finish_ok    = in_acc & ram_ready;
    // A late ready on the final allowed cycle still wins over the abort.
    finish_abort = in_acc & ~ram_ready & (wait_cnt == CW'(TIMEOUT - 1));
    acc_done     = finish_ok | finish_abort;
    stall_if     = if_req & ~if_ack;
    stall_mem    = dm_req & ~dm_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_ce     <= 1'b0;
      ram_addr   <= ZERO_WORD;
      ram_we     <= 4'b0000;
      ram_wdata  <= ZERO_WORD;
      if_rdata   <= ZERO_WORD;
      dm_rdata   <= ZERO_WORD;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      bus_err    <= 1'b0;
      wait_cnt   <= '0;
      last_grant <= OWNER_IF;
    end else begin
      if_ack  <= 1'b0;
      dm_ack  <= 1'b0;
      bus_err <= 1'b0;
      if (take) begin
        ram_ce     <= 1'b1;
        ram_addr   <= grant_dm ? dm_addr  : if_addr;
        ram_we     <= grant_dm ? dm_we    : 4'b0000;
        ram_wdata  <= grant_dm ? dm_wdata : ZERO_WORD;
        wait_cnt   <= '0;
        last_grant <= grant_dm;
      end else if (acc_done) begin
        ram_ce  <= 1'b0;
        bus_err <= finish_abort;
        if (owner_dm) begin
          dm_ack   <= 1'b1;
          dm_rdata <= finish_ok ? ram_rdata : ZERO_WORD;
        end else begin
          if_ack   <= 1'b1;
          if_rdata <= finish_ok ? ram_rdata : ZERO_WORD;
        end
      end else if (in_acc) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: expected responses queued at issue, checked by a negedge monitor.
module tb_ram_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_we;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_ack, dm_ack;
  logic        ram_ce, ram_ready;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_we;
  logic        stall_if, stall_mem, bus_err;

  ram_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .ram_ce(ram_ce), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dm;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          ready_delay = 0;
  int          ram_cnt = 0;
  logic [31:0] rd_val = 32'h0;
  logic [31:0] mdl_if_rdata = 32'h0, mdl_dm_rdata = 32'h0;
  bit          prev_if_ack = 0, prev_dm_ack = 0;
  int          l0, l1, l2, l3;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input bit dm, input logic [31:0] a, input logic [3:0] we,
                      input logic [31:0] wd, input logic [31:0] rd, input bit err);
    exp_t e;
    e.dm = dm; e.addr = a; e.we = we; e.wdata = wd; e.rdata = rd; e.err = err;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns clock edges from raising req to seeing ack.
  task automatic access(input bit dm, input logic [31:0] a, input logic [3:0] we,
                        input logic [31:0] wd, output int lat);
    bit got = 0;
    lat = 0;
    if (dm) begin dm_req = 1; dm_addr = a; dm_we = we; dm_wdata = wd; end
    else    begin if_req = 1; if_addr = a; end
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (dm ? dm_ack : if_ack) begin got = 1; break; end
    end
    if (!got) check(dm ? "dm_ack_timeout" : "if_ack_timeout", 72'(got), 72'(1));
    if (dm) dm_req = 0; else if_req = 0;
  endtask

  // RAM model: raises ready on the ready_delay-th cycle (0-based) of ram_ce.
  initial begin
    ram_ready = 0; ram_rdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (ram_ce) begin
        ram_ready = (ram_cnt == ready_delay);
        ram_rdata = ram_ready ? rd_val : 32'hBAD0_BAD0;
        ram_cnt++;
      end else begin
        ram_cnt = 0; ram_ready = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("stall", 72'({stall_if, stall_mem}), 72'({if_req & ~if_ack, dm_req & ~dm_ack}));
      if (ram_ce) begin
        if (q.size() == 0) check("ram_ce_unexpected", 72'(ram_ce), 72'(0));
        else check("ram_bus", {ram_addr, ram_we, ram_wdata, 4'h0},
                   {q[0].addr, q[0].we, q[0].wdata, 4'h0});
      end
      if (if_ack | dm_ack) begin
        if (if_ack && prev_if_ack) check("if_ack_pulse", 72'(prev_if_ack), 72'(0));
        if (dm_ack && prev_dm_ack) check("dm_ack_pulse", 72'(prev_dm_ack), 72'(0));
        if (q.size() == 0) begin
          check("ack_unexpected", 72'({if_ack, dm_ack}), 72'(0));
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.dm) mdl_dm_rdata = e.rdata; else mdl_if_rdata = e.rdata;
          check("ack_owner", 72'({if_ack, dm_ack}), 72'(e.dm ? 2'b01 : 2'b10));
          check("bus_err", 72'(bus_err), 72'(e.err));
          check("if_rdata", 72'(if_rdata), 72'(mdl_if_rdata));
          check("dm_rdata", 72'(dm_rdata), 72'(mdl_dm_rdata));
        end
      end else begin
        check("bus_err_idle", 72'(bus_err), 72'(0));
      end
    end
    prev_if_ack = if_ack;
    prev_dm_ack = dm_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst = 1; if_req = 0; dm_req = 0;
    if_addr = 0; dm_addr = 0; dm_we = 0; dm_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_ce_we", 72'({ram_ce, ram_we}), 72'(0));
    check("rst_ram_addr_wdata", {ram_addr, ram_wdata, 8'h0}, 72'(0));
    check("rst_rdata", {if_rdata, dm_rdata, 8'h0}, 72'(0));
    check("rst_ack_err", 72'({if_ack, dm_ack, bus_err}), 72'(0));
    rst = 0;

    // Both ports requesting back to back: DM wins first contention, then alternation.
    ready_delay = 0; rd_val = 32'h1111_2222;
    push(1, 32'h40, 4'h0, 32'h0, 32'h1111_2222, 0);
    push(0, 32'h80, 4'h0, 32'h0, 32'h1111_2222, 0);
    push(1, 32'h44, 4'h0, 32'h0, 32'h1111_2222, 0);
    push(0, 32'h84, 4'h0, 32'h0, 32'h1111_2222, 0);
    fork
      begin access(1, 32'h40, 4'h0, 32'h0, l0); @(posedge clk); #1; access(1, 32'h44, 4'h0, 32'h0, l2); end
      begin access(0, 32'h80, 4'h0, 32'h0, l1); @(posedge clk); #1; access(0, 32'h84, 4'h0, 32'h0, l3); end
    join
    check("min_latency", 72'(l0), 72'(2));

    // IF read, ready one cycle after ce.
    repeat (2) @(posedge clk); #1;
    ready_delay = 1; rd_val = 32'hDEAD_BEEF;
    push(0, 32'h1000, 4'h0, 32'h0, 32'hDEAD_BEEF, 0);
    access(0, 32'h1000, 4'h0, 32'h0, l0);
    check("if_read_latency", 72'(l0), 72'(3));

    // DM partial write held stable for three ce cycles.
    repeat (2) @(posedge clk); #1;
    ready_delay = 2; rd_val = 32'h5555_AAAA;
    push(1, 32'h100, 4'b0011, 32'h0000_ABCD, 32'h5555_AAAA, 0);
    access(1, 32'h100, 4'b0011, 32'h0000_ABCD, l0);
    check("dm_write_latency", 72'(l0), 72'(4));

    // Contention right after a DM grant separates the two arbitration modes.
    repeat (2) @(posedge clk); #1;
    ready_delay = 0; rd_val = 32'hCAFE_0001;
`ifdef RAM_ARB_RR_EN
    push(0, 32'h600, 4'h0, 32'h0, 32'hCAFE_0001, 0);
    push(1, 32'h700, 4'h0, 32'h0, 32'hCAFE_0001, 0);
`else
    push(1, 32'h700, 4'h0, 32'h0, 32'hCAFE_0001, 0);
    push(0, 32'h600, 4'h0, 32'h0, 32'hCAFE_0001, 0);
`endif
    fork
      access(0, 32'h600, 4'h0, 32'h0, l0);
      access(1, 32'h700, 4'h0, 32'h0, l1);
    join

    // RAM never ready: abort after TO wait cycles.
    repeat (2) @(posedge clk); #1;
    ready_delay = 100;
    push(1, 32'h200, 4'h0, 32'h0, 32'h0, 1);
    access(1, 32'h200, 4'h0, 32'h0, l0);
    check("timeout_latency", 72'(l0), 72'(TO + 1));

    // Ready arriving on the last allowed cycle completes normally.
    repeat (2) @(posedge clk); #1;
    ready_delay = TO - 1; rd_val = 32'h7777_0007;
    push(0, 32'h300, 4'h0, 32'h0, 32'h7777_0007, 0);
    access(0, 32'h300, 4'h0, 32'h0, l0);
    check("boundary_latency", 72'(l0), 72'(TO + 1));

    repeat (2) @(posedge clk); #1;
    ready_delay = 0; rd_val = 32'h1234_5678;
    push(1, 32'h204, 4'h0, 32'h0, 32'h1234_5678, 0);
    access(1, 32'h204, 4'h0, 32'h0, l0);
    check("after_timeout_latency", 72'(l0), 72'(2));

    // Reset in the second DM_ACC cycle abandons the access silently.
    repeat (2) @(posedge clk); #1;
    ready_delay = 100;
    push(1, 32'h400, 4'h0, 32'h0, 32'h0, 0);
    dm_req = 1; dm_addr = 32'h400; dm_we = 4'h0; dm_wdata = 32'h0;
    @(posedge clk); #1;
    check("dm_granted", 72'(ram_ce), 72'(1));
    @(posedge clk); #1;
    rst = 1; dm_req = 0;
    @(posedge clk); #1;
    check("rst_mid_ce_ack_err", 72'({ram_ce, dm_ack, if_ack, bus_err}), 72'(0));
    check("rst_mid_rdata", {if_rdata, dm_rdata, 8'h0}, 72'(0));
    q.delete();
    mdl_if_rdata = 32'h0; mdl_dm_rdata = 32'h0;
    rst = 0;
    ready_delay = 0; rd_val = 32'hA1B2_C3D4;
    push(0, 32'h500, 4'h0, 32'h0, 32'hA1B2_C3D4, 0);
    if_req = 1; if_addr = 32'h500;
    @(posedge clk); #1;
    check("post_rst_grant", {ram_ce, ram_addr, 39'h0}, {1'b1, 32'h500, 39'h0});
    for (int i = 0; i < 20 && !if_ack; i++) begin
      @(posedge clk); #1;
    end
    check("post_rst_ack", 72'(if_ack), 72'(1));
    if_req = 0;

    repeat (3) @(posedge clk); #1;
    check("queue_drained", 72'(q.size()), 72'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for ram_ready before an aborted access is flagged.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports if_req input 1, if_addr input 32, if_rdata output 32 and if_ack output 1: instruction-fetch read port.
REQ-005 SHALL have ports dm_req input 1, dm_addr input 32, dm_we input 4, dm_wdata input 32, dm_rdata output 32 and dm_ack output 1: data port; dm_we=0 means read, otherwise byte-lane write mask.
REQ-006 SHALL have ports ram_ce output 1, ram_addr output 32, ram_we output 4, ram_wdata output 32, ram_rdata input 32 and ram_ready input 1: single shared RAM port.
REQ-007 SHALL have ports stall_if output 1, stall_mem output 1 and bus_err output 1: pipeline stall requests and timeout flag.

Function
REQ-008 SHALL implement FSM states IDLE, IF_ACC and DM_ACC, plus a registered owner/last_grant bit.
REQ-009 In IDLE, SHALL grant on the cycle a request is sampled: next state IF_ACC or DM_ACC, with ram_* outputs registered from the latched request.
REQ-010 When only one of if_req and dm_req is high, SHALL grant that port.
REQ-011 When both requests are high, SHALL arbitrate per REQ-024/REQ-025.
REQ-012 In IF_ACC and DM_ACC, SHALL hold ram_ce=1 and keep ram_addr, ram_we and ram_wdata stable; ram_we SHALL be 0 in IF_ACC.
REQ-013 When ram_ready is sampled 1, SHALL capture ram_rdata into the owner's rdata register, pulse the owner's ack for exactly 1 cycle (the next cycle), drop ram_ce and return to IDLE.
REQ-014 Minimum latency SHALL be 2 cycles from request sampled to ack high, with at least one IDLE cycle between accesses.
REQ-015 A requester SHALL drop req in its ack cycle; the arbiter SHALL ignore a port's req while that port's ack is high.
REQ-016 if_rdata and dm_rdata SHALL hold their last captured value until the next access by the same port.
REQ-017 stall_if SHALL equal if_req & ~if_ack, and stall_mem SHALL equal dm_req & ~dm_ack, combinationally.
REQ-018 A wait counter SHALL clear on grant and increment each access cycle with ram_ready=0.
REQ-019 When the wait counter reaches TIMEOUT, SHALL abort the access: owner ack=1, owner rdata=0, bus_err=1 for the same single cycle, then IDLE.
REQ-020 If ram_ready=1 in the same cycle the counter reaches TIMEOUT, SHALL complete normally with no bus_err.
REQ-021 Requests changing while an access is in progress SHALL NOT alter ram_* outputs.

Reset
REQ-022 When rst=1 at a clock edge, SHALL force state=IDLE; ram_ce=0; ram_addr, ram_wdata, if_rdata and dm_rdata=0; ram_we=0; if_ack, dm_ack and bus_err=0; wait counter=0; last_grant=IF.
REQ-023 Reset mid-access SHALL abandon the transaction silently with no ack and no bus_err.

Configuration
REQ-024 With RAM_ARB_RR_EN defined, SHALL grant simultaneous requests to the port not granted last, updating last_grant on every grant; DM wins the first contention after reset.
REQ-025 Without RAM_ARB_RR_EN, SHALL give DM fixed priority on contention, leaving last_grant unused.

Structure
REQ-026 State encodings, owner encoding (IF=0, DM=1) and a ZeroWord-style constant SHALL live in the shared defines header.
REQ-027 Arbitration decision logic SHALL be a sub-module ram_arb_pick (inputs if_req, dm_req, last_grant; output grant_dm, grant_valid); the RR/fixed macro SHALL be confined to it.

Verification
REQ-028 IF read, ram_ready one cycle after ram_ce, ram_rdata=32'hDEADBEEF -> if_ack pulses 1 cycle, if_rdata=32'hDEADBEEF, stall_if high until ack.
REQ-029 DM write addr=32'h100, dm_we=4'b0011, wdata=32'h0000ABCD -> ram_we=4'b0011 and ram_addr=32'h100 stable until ready; dm_ack 1 cycle; if_rdata unchanged.
REQ-030 Both requesting continuously for 4 accesses -> with RAM_ARB_RR_EN grants DM,IF,DM,IF; without it, DM on every contention.
REQ-031 TIMEOUT=8, ram_ready held 0 -> 8 wait cycles, then dm_ack=1, bus_err=1, dm_rdata=0 in one cycle; next request served normally.
REQ-032 rst asserted in the second cycle of a DM_ACC -> next cycle ram_ce=0, no ack, no bus_err; a post-reset if_req is granted first-cycle.
